ifetch_seq: RTL and testbench

//  Instruction-fetch sequencer for the synchronous instruction ROM (1-cycle read latency, word-addressed).

---
 rtl/ifetch_seq_if.sv | 31 +++
 rtl/ifetch_seq.sv | 156 +++++++++++++++
 tb/tb_ifetch_seq.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifetch_seq_if.sv
// Instruction-fetch bus: ROM address/data on one side, valid/ready instruction stream to decode on the other.
// master = fetch sequencer, slave = ROM + decode environment.
interface ifetch_seq_if #(
    parameter int unsigned AW = 6,
    parameter int unsigned DW = 32
) ();
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data;
    logic          inst_valid;
    logic          inst_ready;
    logic [DW-1:0] inst_data;
    logic [AW-1:0] inst_pc;

    modport master (
        output rom_addr,
        input  rom_data,
        output inst_valid,
        input  inst_ready,
        output inst_data,
        output inst_pc
    );

    modport slave (
        input  rom_addr,
        output rom_data,
        input  inst_valid,
        output inst_ready,
        input  inst_data,
        input  inst_pc
    );
endinterface

// File: rtl/ifetch_seq.sv
// Instruction-fetch sequencer for a 1-cycle-latency word-addressed ROM with a small output queue.
// Optional halt detection is enabled by defining IFETCH_HALT_EN.
module ifetch_seq #(
    parameter int unsigned   AW        = 6,
    parameter int unsigned   DW        = 32,
    parameter int unsigned   DEPTH     = 2,
    parameter logic [AW-1:0] RESET_PC  = '0,
    parameter logic [DW-1:0] HALT_WORD = '1
) (
    input  logic          clka,
    input  logic          rst_n,
    input  logic          start,
    input  logic          stop,
    input  logic          redirect_vld,
    input  logic [AW-1:0] redirect_pc,
    ifetch_seq_if.master  bus,
    output logic          busy,
    output logic          halted
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned SW = CW + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1
`ifdef IFETCH_HALT_EN
        , ST_HALT = 2'd2
`endif
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] pc;
    logic [AW-1:0] pc_nxt;
    logic          inflight;
    logic [AW-1:0] inflight_pc;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic [CW-1:0] wr_idx;
    logic          valid_q;
    logic [DW-1:0] q_data [DEPTH];
    logic [AW-1:0] q_pc   [DEPTH];

    logic fetching;
    logic pop;
    logic flush;
    logic push;
    logic room;
    logic issue;
    logic halt_cap;

    assign bus.rom_addr   = pc;
    assign bus.inst_valid = valid_q;
    assign bus.inst_data  = q_data[0];
    assign bus.inst_pc    = q_pc[0];

    // Next-state decode; priority redirect > start > stop > halt capture.
    always_comb begin
        fetching  = (state == ST_FETCH);
        pop       = valid_q & bus.inst_ready;
        flush     = fetching & (redirect_vld | start);
        push      = inflight & ~flush;
        halt_cap  = 1'b0;
`ifdef IFETCH_HALT_EN
        halt_cap  = fetching & push & ~stop & (bus.rom_data == HALT_WORD);
`endif
        room      = (SW'(count) + SW'(inflight)) < (SW'(DEPTH) + SW'(pop));
        issue     = fetching & ~redirect_vld & ~start & ~stop & ~halt_cap & room;
        wr_idx    = count - CW'(pop);
        count_nxt = flush ? '0 : (count + CW'(push) - CW'(pop));
        state_nxt = state;
        pc_nxt    = pc;
        if (flush) begin
            pc_nxt = redirect_vld ? redirect_pc : RESET_PC;
        end else if (start) begin
            state_nxt = ST_FETCH;
            pc_nxt    = RESET_PC;
        end else begin
            if (issue) begin
                pc_nxt = pc + AW'(1);
            end
            if (fetching && stop) begin
                state_nxt = ST_IDLE;
            end
`ifdef IFETCH_HALT_EN
            else if (halt_cap) begin
                state_nxt = ST_HALT;
            end
`endif
        end
    end

    // Control state, PC, in-flight tracking and status.
    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            count       <= '0;
            valid_q     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            inflight    <= issue;
            if (issue) begin
                inflight_pc <= pc;
            end
            count       <= count_nxt;
            valid_q     <= (count_nxt != '0);
            busy        <= (state_nxt != ST_IDLE) || (count_nxt != '0) || issue;
        end
    end

    // Shift queue: entry 0 is the head; it keeps its value when the queue empties.
    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                q_data[i] <= '0;
                q_pc[i]   <= '0;
            end
        end else begin
            if (pop && !flush && (count > CW'(1))) begin
                for (int i = 0; i < int'(DEPTH) - 1; i++) begin
                    q_data[i] <= q_data[i+1];
                    q_pc[i]   <= q_pc[i+1];
                end
            end
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (push && (wr_idx == CW'(i))) begin
                    q_data[i] <= bus.rom_data;
                    q_pc[i]   <= inflight_pc;
                end
            end
        end
    end

`ifdef IFETCH_HALT_EN
    // The halt word is always the last queued entry, so the final pop in HALT delivers it.
    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            halted <= 1'b0;
        end else if (start) begin
            halted <= 1'b0;
        end else if ((state == ST_HALT) && pop && (count == CW'(1))) begin
            halted <= 1'b1;
        end
    end
`else
    logic unused_halt_word;
    assign unused_halt_word = ^HALT_WORD;
    assign halted           = 1'b0;
`endif

endmodule

// File: tb/tb_ifetch_seq.sv
// Directed bench for ifetch_seq: a stream-order model checked every cycle plus literal latency/sequence checks.
module tb_ifetch_seq;
    localparam int unsigned   AW        = 6;
    localparam int unsigned   DW        = 32;
    localparam int unsigned   DEPTH     = 2;
    localparam logic [AW-1:0] RESET_PC  = '0;
    localparam logic [DW-1:0] HALT_WORD = 32'hFFFF_FFFF;

    logic          clka = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          redirect_vld = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic          busy;
    logic          halted;

    ifetch_seq_if #(.AW(AW), .DW(DW)) bus ();

    ifetch_seq #(
        .AW(AW), .DW(DW), .DEPTH(DEPTH), .RESET_PC(RESET_PC), .HALT_WORD(HALT_WORD)
    ) dut (
        .clka        (clka),
        .rst_n       (rst_n),
        .start       (start),
        .stop        (stop),
        .redirect_vld(redirect_vld),
        .redirect_pc (redirect_pc),
        .bus         (bus.master),
        .busy        (busy),
        .halted      (halted)
    );

    always #5 clka = ~clka;

    logic [DW-1:0] rom [64];
    always @(posedge clka) bus.rom_data <= rom[bus.rom_addr];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Stream model: delivered words are consecutive PCs from the last start/redirect target.
    logic [AW-1:0] exp_pc = '0;
    bit            m_fetching = 1'b0;
    bit            prev_stall = 1'b0;
    bit            prev_flush = 1'b0;
    bit            halt_popped = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic [AW-1:0] prev_pc = '0;

    always @(negedge clka) begin
        if (!rst_n) begin
            chk("rst_rom_addr", 64'(bus.rom_addr), 64'(RESET_PC));
            chk("rst_inst_valid", 64'(bus.inst_valid), 64'd0);
            chk("rst_inst_data", 64'(bus.inst_data), 64'd0);
            chk("rst_inst_pc", 64'(bus.inst_pc), 64'd0);
            chk("rst_busy", 64'(busy), 64'd0);
            chk("rst_halted", 64'(halted), 64'd0);
            exp_pc      = RESET_PC;
            m_fetching  = 1'b0;
            prev_stall  = 1'b0;
            prev_flush  = 1'b0;
            halt_popped = 1'b0;
        end else begin
            if (prev_flush)
                chk("valid_after_flush", 64'(bus.inst_valid), 64'd0);
            if (prev_stall && !prev_flush) begin
                chk("stall_valid", 64'(bus.inst_valid), 64'd1);
                chk("stall_data", 64'(bus.inst_data), 64'(prev_data));
                chk("stall_pc", 64'(bus.inst_pc), 64'(prev_pc));
            end
            if (m_fetching)
                chk("busy_fetch", 64'(busy), 64'd1);
            if (bus.inst_valid && bus.inst_ready) begin
                if (halt_popped)
                    chk("word_after_halt", 64'(bus.inst_valid), 64'd0);
                chk("order_pc", 64'(bus.inst_pc), 64'(exp_pc));
                chk("order_data", 64'(bus.inst_data), 64'(rom[exp_pc]));
`ifdef IFETCH_HALT_EN
                if (bus.inst_data == HALT_WORD) begin
                    halt_popped = 1'b1;
                    m_fetching  = 1'b0;
                end
`endif
                exp_pc = exp_pc + AW'(1);
            end
            prev_stall = bus.inst_valid && !bus.inst_ready;
            prev_data  = bus.inst_data;
            prev_pc    = bus.inst_pc;
            prev_flush = m_fetching && (redirect_vld || start);
            if (m_fetching && redirect_vld) begin
                exp_pc = redirect_pc;
            end else if (start) begin
                exp_pc      = RESET_PC;
                m_fetching  = 1'b1;
                halt_popped = 1'b0;
            end else if (stop) begin
                m_fetching = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clka);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 40) begin
            step();
            n++;
        end
        chk(name, 64'(busy), 64'd0);
    endtask

    // Start pulse then check first word appears exactly in cycle 3.
    task automatic start_and_check_latency(input string name);
        start = 1'b1;
        step();
        start = 1'b0;
        chk({name, "_c1_valid"}, 64'(bus.inst_valid), 64'd0);
        step();
        chk({name, "_c2_valid"}, 64'(bus.inst_valid), 64'd0);
        step();
        chk({name, "_c3_valid"}, 64'(bus.inst_valid), 64'd1);
        chk({name, "_c3_pc"}, 64'(bus.inst_pc), 64'(RESET_PC));
    endtask

    initial begin
        int n;
        for (int i = 0; i < 64; i++)
            rom[i] = 32'h1000_0000 + 32'(i) * 32'h0001_0003;
        bus.inst_ready = 1'b1;

        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();

        // One word per cycle with ready held high.
        start_and_check_latency("lat");
        for (int k = 1; k < 15; k++) begin
            step();
            chk("stream_valid", 64'(bus.inst_valid), 64'd1);
            chk("stream_pc", 64'(bus.inst_pc), 64'(k));
            chk("stream_data", 64'(bus.inst_data), 64'(rom[AW'(k)]));
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        wait_idle("drain_after_stop1");

        // Ready toggling every cycle.
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 40; k++) begin
            bus.inst_ready = k[0];
            step();
        end
        bus.inst_ready = 1'b1;
        stop = 1'b1;
        step();
        stop = 1'b0;
        wait_idle("drain_after_stop2");

        // Redirect to 9 while 4 and 5 sit in the queue.
        start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (!(bus.inst_valid && bus.inst_pc == AW'(4)) && n < 20) begin
            step();
            n++;
        end
        chk("reach_pc4", 64'(bus.inst_pc), 64'd4);
        bus.inst_ready = 1'b0;
        step();
        chk("queued_head_pc4", 64'(bus.inst_pc), 64'd4);
        redirect_vld = 1'b1;
        redirect_pc  = AW'(9);
        step();
        redirect_vld   = 1'b0;
        bus.inst_ready = 1'b1;
        chk("redir_r1_valid", 64'(bus.inst_valid), 64'd0);
        step();
        chk("redir_r2_valid", 64'(bus.inst_valid), 64'd0);
        step();
        chk("redir_r3_valid", 64'(bus.inst_valid), 64'd1);
        chk("redir_r3_pc", 64'(bus.inst_pc), 64'd9);

        // Redirect to 62 in a cycle that also pops, then wrap 62,63,0,1.
        step();
        chk("pop_with_redirect_valid", 64'(bus.inst_valid), 64'd1);
        redirect_vld = 1'b1;
        redirect_pc  = AW'(62);
        step();
        redirect_vld = 1'b0;
        step();
        step();
        chk("wrap_pc62", 64'(bus.inst_pc), 64'd62);
        step();
        chk("wrap_pc63", 64'(bus.inst_pc), 64'd63);
        step();
        chk("wrap_pc0", 64'(bus.inst_pc), 64'd0);
        step();
        chk("wrap_pc1", 64'(bus.inst_pc), 64'd1);
        chk("wrap_data1", 64'(bus.inst_data), 64'(rom[1]));

        // Asynchronous reset mid-stream, then restart from RESET_PC.
        step();
        rst_n = 1'b0;
        #1;
        chk("midrst_rom_addr", 64'(bus.rom_addr), 64'(RESET_PC));
        chk("midrst_valid", 64'(bus.inst_valid), 64'd0);
        chk("midrst_data", 64'(bus.inst_data), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        step();
        rst_n = 1'b1;
        step();
        start_and_check_latency("restart");
        repeat (4) step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        wait_idle("drain_after_stop3");

`ifdef IFETCH_HALT_EN
        // Word 5 is the halt word: 0..5 delivered, then nothing.
        rom[5] = HALT_WORD;
        start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (!halted && n < 40) begin
            step();
            n++;
        end
        chk("halt_flag", 64'(halted), 64'd1);
        chk("halt_word_popped", 64'(halt_popped), 64'd1);
        repeat (5) begin
            step();
            chk("no_word_after_halt", 64'(bus.inst_valid), 64'd0);
        end
        chk("busy_in_halt", 64'(busy), 64'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end
endmodule
